// File: rtl/dds_symbol_source_pkg.sv
`default_nettype none
//==============================================================================
// Module      : dds_symbol_source_pkg
// Description : Shared constants and helpers for the DDS symbol source:
//               quarter-wave table geometry, amplitude, LFSR seed/taps and
//               datapath pipeline depth.
// Revision    : 1.0 - initial release
//==============================================================================
package dds_symbol_source_pkg;

    // Quarter-wave sine table geometry
    localparam int QTR_DEPTH = 1024;
    localparam int QTR_AW    = 10;
    localparam int QTR_DW    = 11;
    localparam int AMPLITUDE = 2047;

    // Output sample width (signed)
    localparam int CARRIER_W = 12;

    // Data LFSR: x^15 + x^14 + 1, shifted left, output on bit 0
    localparam int               LFSR_W     = 15;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;
    localparam int               LFSR_TAP_A = 14;
    localparam int               LFSR_TAP_B = 13;

    // Registered stages between the phase register and the outputs
    localparam int PIPE_DEPTH = 3;

    // One LFSR advance; an all-zero state reloads the seed so the
    // generator can never lock up.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        if (s == '0) begin
            return LFSR_SEED;
        end
        return {s[LFSR_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
    endfunction

    // Quarter-wave entry i, sampled at the centre of each phase bin so the
    // table never produces zero and its mirror image is exact.
    function automatic logic [QTR_DW-1:0] qtr_sine(input int idx);
        real angle;
        real value;
        angle = 2.0 * 3.14159265358979323846 * (real'(idx) + 0.5) / real'(4 * QTR_DEPTH);
        value = real'(AMPLITUDE) * $sin(angle) + 0.5;
        return QTR_DW'($rtoi(value));
    endfunction

endpackage : dds_symbol_source_pkg
`default_nettype wire

// File: rtl/quarter_sine_rom.sv
`default_nettype none
//==============================================================================
// Module      : quarter_sine_rom
// Description : 1024 x 11 unsigned quarter-wave sine table with a registered
//               read port. Holds its output while i_en is low.
// Revision    : 1.0 - initial release
//==============================================================================
module quarter_sine_rom
    import dds_symbol_source_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [QTR_AW-1:0] i_addr,
    output logic [QTR_DW-1:0] o_data
);

    logic [QTR_DW-1:0] w_table [QTR_DEPTH];
    logic [QTR_DW-1:0] r_data;

    // Table contents are elaboration-time constants
    generate
        for (genvar gi = 0; gi < QTR_DEPTH; gi++) begin : g_entry
            assign w_table[gi] = qtr_sine(gi);
        end
    endgenerate

    // Registered table read, advanced only on enabled cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= w_table[i_addr];
        end
    end

    assign o_data = r_data;

endmodule : quarter_sine_rom
`default_nettype wire

// File: rtl/dds_symbol_source.sv
`default_nettype none
//==============================================================================
// Module      : dds_symbol_source
// Description : DDS carrier generator with a symbol-rate PN data source.
//               Phase accumulator -> 3-stage sine pipeline (address, table
//               read, sign); symbol counter and LFSR data bit delayed through
//               the same stages so data edges align with sym_strobe.
// Revision    : 1.0 - initial release
//==============================================================================
module dds_symbol_source
    import dds_symbol_source_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int SYM_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [PHASE_W-1:0]          tuning_word,
    input  logic                        tw_load,
    input  logic                        phase_clr,
    input  logic [SYM_W-1:0]            sym_div,
    output logic signed [CARRIER_W-1:0] carrier,
    output logic                        lfsr0,
    output logic                        sym_strobe,
    output logic                        valid
);

    localparam logic [1:0] C_FILL_LAST = 2'(PIPE_DEPTH - 1);

    // Accumulator, tuning word, symbol timing
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_tw;
    logic [SYM_W-1:0]   r_cnt;
    logic [LFSR_W-1:0]  r_lfsr;
    logic               w_wrap;

    // Pipeline
    logic [1:0]          w_quad;
    logic [QTR_AW-1:0]   w_a;
    logic [QTR_AW-1:0]   r_s1_addr;
    logic                r_s1_neg, r_s1_strb, r_s1_bit;
    logic                r_s2_neg, r_s2_strb, r_s2_bit;
    logic [QTR_DW-1:0]   w_rom_data;
    logic [CARRIER_W-1:0] w_mag;
    logic [CARRIER_W-1:0] r_carrier;
    logic                r_strb, r_bit;

    // Valid tracking
    logic [1:0] r_fill;
    logic       w_primed;
    logic       r_valid;

    // ">=" rather than "==" so a shrunken sym_div wraps on the next cycle
    assign w_wrap = (r_cnt >= sym_div);

    // Phase accumulator; clear wins over accumulation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (en) begin
            r_phase <= phase_clr ? '0 : (r_phase + r_tw);
        end
    end

    // Tuning word capture; it is used from the following accumulation on
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tw <= '0;
        end else if (tw_load) begin
            r_tw <= tuning_word;
        end
    end

    // Symbol counter; each wrap starts a new symbol and steps the LFSR
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_lfsr <= LFSR_SEED;
        end else if (en) begin
            if (w_wrap) begin
                r_cnt  <= '0;
                r_lfsr <= lfsr_step(r_lfsr);
            end else begin
                r_cnt  <= r_cnt + SYM_W'(1);
            end
        end
    end

    // Quadrant 1 and 3 read the table mirrored; 1023-a is the bitwise inverse
    assign w_quad = r_phase[PHASE_W-1 -: 2];
    assign w_a    = r_phase[PHASE_W-3 -: QTR_AW];

    // Stage 1: table address plus sign and symbol side-band
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_addr <= '0;
            r_s1_neg  <= 1'b0;
            r_s1_strb <= 1'b0;
            r_s1_bit  <= 1'b0;
        end else if (en) begin
            r_s1_addr <= w_quad[0] ? ~w_a : w_a;
            r_s1_neg  <= w_quad[1];
            r_s1_strb <= (r_cnt == '0);
            r_s1_bit  <= r_lfsr[0];
        end
    end

    // Stage 2: table read (inside the ROM) with side-band alongside
    quarter_sine_rom u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (en),
        .i_addr (r_s1_addr),
        .o_data (w_rom_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_neg  <= 1'b0;
            r_s2_strb <= 1'b0;
            r_s2_bit  <= 1'b0;
        end else if (en) begin
            r_s2_neg  <= r_s1_neg;
            r_s2_strb <= r_s1_strb;
            r_s2_bit  <= r_s1_bit;
        end
    end

    // Stage 3: apply sign; magnitude is at most 2047 so -2048 cannot occur
    assign w_mag = {1'b0, w_rom_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_carrier <= '0;
            r_strb    <= 1'b0;
            r_bit     <= 1'b0;
        end else if (en) begin
            r_carrier <= r_s2_neg ? (-w_mag) : w_mag;
            r_strb    <= r_s2_strb;
            r_bit     <= r_s2_bit;
        end
    end

    // Valid marks each freshly produced sample once the pipeline has filled;
    // held contents are not re-flagged, so a resume neither gaps nor repeats
    assign w_primed = (r_fill >= C_FILL_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fill  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= en && w_primed;
            if (en && !w_primed) begin
                r_fill <= r_fill + 2'd1;
            end
        end
    end

    assign carrier    = r_carrier;
    assign lfsr0      = r_bit;
    assign sym_strobe = r_strb;
    assign valid      = r_valid;

endmodule : dds_symbol_source
`default_nettype wire

// File: tb/tb_dds_symbol_source.sv
`default_nettype none
//==============================================================================
// Module      : tb_dds_symbol_source
// Description : Self-checking bench for dds_symbol_source. A behavioural model
//               produces one expected sample per enabled cycle into a queue;
//               every valid DUT sample is checked against the queue head.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_dds_symbol_source;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic [31:0]        tuning_word;
    logic               tw_load;
    logic               phase_clr;
    logic [15:0]        sym_div;
    logic signed [11:0] carrier;
    logic               lfsr0;
    logic               sym_strobe;
    logic               valid;

    always #5 clk = ~clk;

    dds_symbol_source #(
        .PHASE_W (32),
        .SYM_W   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .tuning_word (tuning_word),
        .tw_load     (tw_load),
        .phase_clr   (phase_clr),
        .sym_div     (sym_div),
        .carrier     (carrier),
        .lfsr0       (lfsr0),
        .sym_strobe  (sym_strobe),
        .valid       (valid)
    );

    typedef struct {
        int car;
        bit strb;
        bit dbit;
    } sample_t;

    int      n_checks = 0;
    int      n_errors = 0;
    int      qtab [1024];
    sample_t exp_q [$];
    sample_t m_last;
    bit      m_has_last;
    bit [31:0] m_phase;
    bit [31:0] m_tw;
    int      m_cnt;
    int      m_lfsr;
    int      m_en_cnt;
    bit      m_valid;
    bit      m_inrst;
    bit      chk_first;

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int sine_of(input bit [31:0] ph);
        bit [11:0] top;
        int a;
        top = ph[31:20];
        a   = int'(top[9:0]);
        case (top[11:10])
            2'd0:    return  qtab[a];
            2'd1:    return  qtab[1023 - a];
            2'd2:    return -qtab[a];
            default: return -qtab[1023 - a];
        endcase
    endfunction

    function automatic int lfsr_next(input int s);
        if (s == 0) return 1;
        return ((s << 1) | (((s >> 14) ^ (s >> 13)) & 1)) & 'h7fff;
    endfunction

    task automatic model_edge(input bit r, input bit e, input bit tl, input bit pc,
                              input bit [31:0] tw, input bit [15:0] sd);
        if (!r) begin
            m_phase = 0; m_tw = 0; m_cnt = 0; m_lfsr = 1;
            m_en_cnt = 0; m_valid = 0; m_inrst = 1; m_has_last = 0;
            exp_q.delete();
            return;
        end
        m_inrst = 0;
        if (e) begin
            exp_q.push_back('{car: sine_of(m_phase), strb: (m_cnt == 0), dbit: bit'(m_lfsr & 1)});
            m_en_cnt++;
            m_valid = (m_en_cnt >= 3);
            m_phase = pc ? 32'd0 : m_phase + m_tw;
            if (m_cnt >= int'(sd)) begin
                m_cnt  = 0;
                m_lfsr = lfsr_next(m_lfsr);
            end else begin
                m_cnt++;
            end
        end else begin
            m_valid = 0;
        end
        if (tl) m_tw = tw;
    endtask

    task automatic check_outputs();
        sample_t s;
        if (m_inrst) begin
            check_val("rst_carrier", carrier, 0);
            check_val("rst_lfsr0", lfsr0, 0);
            check_val("rst_strobe", sym_strobe, 0);
            check_val("rst_valid", valid, 0);
            return;
        end
        check_val("valid", valid, m_valid);
        if (m_valid) begin
            s = exp_q.pop_front();
            check_val("carrier", carrier, s.car);
            check_val("sym_strobe", sym_strobe, s.strb);
            check_val("lfsr0", lfsr0, s.dbit);
            if (chk_first) begin
                check_val("first_sample", carrier, 2);
                check_val("first_strobe", sym_strobe, 1);
                chk_first = 0;
            end
            m_last     = s;
            m_has_last = 1;
        end else if (m_has_last) begin
            check_val("hold_carrier", carrier, m_last.car);
            check_val("hold_strobe", sym_strobe, m_last.strb);
            check_val("hold_lfsr0", lfsr0, m_last.dbit);
        end
    endtask

    task automatic tick();
        bit r, e, tl, pc;
        bit [31:0] tw;
        bit [15:0] sd;
        r = rst_n; e = en; tl = tw_load; pc = phase_clr; tw = tuning_word; sd = sym_div;
        @(posedge clk);
        model_edge(r, e, tl, pc, tw, sd);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            qtab[i] = $rtoi(2047.0 * $sin(2.0 * 3.141592653589793 * (real'(i) + 0.5) / 4096.0) + 0.5);
        end
        chk_first = 0;
        m_inrst   = 1;
        rst_n = 1'b0; en = 1'b0; tw_load = 1'b0; phase_clr = 1'b0;
        tuning_word = '0; sym_div = 16'd9;
        repeat (3) tick();

        // Power-on run: 2^20 step, symbol period 10, more than a full carrier period
        rst_n = 1'b1; en = 1'b1; tw_load = 1'b1; tuning_word = 32'h0010_0000; chk_first = 1;
        tick();
        tw_load = 1'b0;
        repeat (4200) tick();

        // Hold for 5 cycles mid-symbol, then resume
        en = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        repeat (20) tick();

        // Clear and load together: quadrant-stepping carrier at 2^30
        phase_clr = 1'b1; tw_load = 1'b1; tuning_word = 32'h4000_0000;
        tick();
        phase_clr = 1'b0; tw_load = 1'b0;
        repeat (16) tick();

        // Shrink sym_div below the running count
        sym_div = 16'd40;
        repeat (30) tick();
        sym_div = 16'd3;
        repeat (20) tick();

        // One symbol per clock
        sym_div = 16'd0;
        repeat (50) tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            en          = ($urandom_range(0, 9) != 0);
            tw_load     = ($urandom_range(0, 30) == 0);
            tuning_word = $urandom;
            phase_clr   = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 150) == 0) sym_div = 16'($urandom_range(0, 12));
            tick();
        end
        tw_load = 1'b0; phase_clr = 1'b0;

        // Mid-run reset overriding every strobe, then restart as at power-on
        rst_n = 1'b0; en = 1'b1; tw_load = 1'b1; phase_clr = 1'b1; tuning_word = 32'h1234_5678;
        repeat (2) tick();
        rst_n = 1'b1; tw_load = 1'b0; phase_clr = 1'b0; sym_div = 16'd9; chk_first = 1;
        repeat (5) tick();
        tw_load = 1'b1; tuning_word = 32'h0010_0000;
        tick();
        tw_load = 1'b0;
        repeat (200) tick();

        check_val("inflight", exp_q.size(), 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_dds_symbol_source
`default_nettype wire
